// File: rtl/gate_unit_pkg.sv
// Shared opcodes and FSM state type for the gate-bank arbiter.
package gate_unit_pkg;
    localparam logic [2:0] OP_NOT     = 3'd0;
    localparam logic [2:0] OP_AND     = 3'd1;
    localparam logic [2:0] OP_OR      = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_NOR     = 3'd4;
    localparam logic [2:0] OP_XOR     = 3'd5;
    localparam logic [2:0] OP_XNOR    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sharing of an external 2-input gate bank among NUM_REQ requesters.
module gate_unit_arbiter
    import gate_unit_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_a,
    input  logic [NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic                 gu_a,
    output logic                 gu_b,
    input  logic [6:0]           gu_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_y,
    output logic                 rsp_err,
    output logic                 busy
);
    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              gu_a_q, gu_a_d, gu_b_q, gu_b_d;
    logic [2:0]        op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_y_q, rsp_y_d, rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [2:0]         sel_op;
    logic [7:0]         y_ext;
    logic               grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign sel_op = req_op[3*int'(arb_idx) +: 3];
    // Index 7 reads the padding zero, so the illegal opcode yields rsp_y=0.
    assign y_ext  = {1'b0, gu_y};

    // rst_n in the grant term keeps req_ready low while reset is held.
    assign grant     = rst_n && (|req_valid) &&
                       (state_q == IDLE || (state_q == RESP && rsp_ready));
    assign req_ready = grant ? arb_gnt : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gu_a_d    = gu_a_q;
        gu_b_d    = gu_b_q;
        op_d      = op_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;

        if (grant) begin
            gu_a_d   = req_a[arb_idx];
            gu_b_d   = req_b[arb_idx];
            op_d     = sel_op;
            id_d     = arb_idx;
            rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
        end

        case (state_q)
            IDLE: if (grant) state_d = EVAL;
            EVAL: begin
                rsp_y_d   = y_ext[op_q];
                rsp_err_d = (op_q == OP_ILLEGAL);
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: if (rsp_ready) state_d = grant ? EVAL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gu_a_q    <= 1'b0;
            gu_b_q    <= 1'b0;
            op_q      <= '0;
            id_q      <= '0;
            rsp_id_q  <= '0;
            rsp_y_q   <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gu_a_q    <= gu_a_d;
            gu_b_q    <= gu_b_d;
            op_q      <= op_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign gu_a      = gu_a_q;
    assign gu_b      = gu_b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter with a behavioural gate bank and model.
module tb_gate_unit_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready, req_a = '0, req_b = '0;
    logic [3*N-1:0] req_op = '0;
    logic         gu_a, gu_b;
    logic [6:0]   gu_y;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_y, rsp_err, busy;
    logic [1:0]   rsp_id;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // External gate bank
    assign gu_y = {~(gu_a ^ gu_b), gu_a ^ gu_b, ~(gu_a | gu_b), ~(gu_a & gu_b),
                   gu_a | gu_b, gu_a & gu_b, ~gu_a};

    gate_unit_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .gu_a(gu_a), .gu_b(gu_b), .gu_y(gu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    function automatic logic gate_ref(input int op, input logic a, input logic b);
        case (op)
            0: return !a;
            1: return a && b;
            2: return a || b;
            3: return !(a && b);
            4: return !(a || b);
            5: return a != b;
            6: return a == b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111; req_a = 4'b1111; req_b = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_checks++; if ({rsp_valid, rsp_y, rsp_err, busy, gu_a, gu_b} !== 6'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=000000", {rsp_valid, rsp_y, rsp_err, busy, gu_a, gu_b}); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0000; req_op = 12'(5) << 3; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = '0; #1;
        n_checks++; if ({req_ready, busy, rsp_valid, gu_a, gu_b} !== 8'b0000_1010) begin n_fail++; $display("FAIL single_eval got=%b exp=00001010", {req_ready, busy, rsp_valid, gu_a, gu_b}); end
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== 5'b1_01_1_0) begin n_fail++; $display("FAIL single_rsp got=%b exp=10110", {rsp_valid, rsp_id, rsp_y, rsp_err}); end
        @(posedge clk);
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        req_valid = 4'b1111; req_a = 4'b1111; req_b = 4'b0000;
        req_op = {3'd4, 3'd3, 3'd2, 3'd1}; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (req_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
            @(posedge clk); @(negedge clk); #1;
            n_checks++; if ({req_ready, rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL rr_eval k=%0d got=%b exp=00000", k, {req_ready, rsp_valid}); end
            @(posedge clk); @(negedge clk); #1;
            n_checks++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'(k % 4), gate_ref(k % 4 + 1, 1'b1, 1'b0)}) begin
                n_fail++; $display("FAIL rr_rsp k=%0d got=%b exp=%b", k, {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'(k % 4), gate_ref(k % 4 + 1, 1'b1, 1'b0)}); end
        end
        req_valid = '0;
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0100; req_op = 12'(1) << 6; rsp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = 4'b1001; req_a = 4'b1111; req_op = (12'(1) << 6) | (12'(2) << 9);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({rsp_valid, rsp_id, rsp_y, req_ready} !== {1'b1, 2'd2, 1'b1, 4'b0000}) begin
                n_fail++; $display("FAIL bp_hold i=%0d got=%b exp=11010000", i, {rsp_valid, rsp_id, rsp_y, req_ready}); end
        end
        @(negedge clk);
        rsp_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release got=%b exp=1000", req_ready); end
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL bp_eval got=%b exp=01", {rsp_valid, busy}); end
        req_valid = '0;
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_y} !== 4'b1_11_1) begin n_fail++; $display("FAIL bp_rsp2 got=%b exp=1111", {rsp_valid, rsp_id, rsp_y}); end
        @(posedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0100; req_op = 12'(7) << 6; rsp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL ill_grant got=%b exp=0100", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0010; req_op = 12'(1) << 3;
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, rsp_err, rsp_y, rsp_id} !== 5'b1_1_0_10) begin n_fail++; $display("FAIL ill_rsp got=%b exp=11010", {rsp_valid, rsp_err, rsp_y, rsp_id}); end
        rsp_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL ill_next_grant got=%b exp=0010", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, rsp_err, rsp_y, rsp_id} !== 5'b1_0_1_01) begin n_fail++; $display("FAIL ill_next_rsp got=%b exp=10101", {rsp_valid, rsp_err, rsp_y, rsp_id}); end
        @(posedge clk);
    endtask

    task automatic test_exhaustive();
        rsp_ready = 1'b1;
        for (int op = 0; op < 7; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                @(negedge clk);
                req_valid = 4'b0001; req_a = {3'b0, ab[1]}; req_b = {3'b0, ab[0]}; req_op = 12'(op);
                #1;
                n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ex_grant op=%0d ab=%0d got=%b exp=0001", op, ab, req_ready); end
                @(posedge clk); @(negedge clk);
                req_valid = '0;
                @(posedge clk); @(negedge clk); #1;
                n_checks++; if ({rsp_valid, rsp_y, rsp_err} !== {1'b1, gate_ref(op, ab[1], ab[0]), 1'b0}) begin
                    n_fail++; $display("FAIL ex_rsp op=%0d ab=%0d got=%b exp=%b", op, ab, {rsp_valid, rsp_y, rsp_err}, {1'b1, gate_ref(op, ab[1], ab[0]), 1'b0}); end
                @(posedge clk);
            end
        end
    endtask

    task automatic test_random();
        int phase, ptr, w, p_id, p_op, e_id, e_op;
        logic p_a, p_b, e_y, e_err, can;
        logic [N-1:0] exp_rdy;
        phase = 0; ptr = 0; p_id = 0; p_op = 0; e_id = 0; e_op = 0;
        p_a = 0; p_b = 0; e_y = 0; e_err = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req_a = 4'($urandom); req_b = 4'($urandom); req_op = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (c >= 396) req_valid = '0;
            #1;
            can = (phase == 0) || (phase == 2 && rsp_ready);
            w = -1;
            if (can)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
            exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            n_checks++; if (rsp_valid !== (phase == 2)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, phase == 2); end
            if (phase == 2) begin
                n_checks++; if ({rsp_id, rsp_y, rsp_err} !== {2'(e_id), e_y, e_err}) begin
                    n_fail++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, {rsp_id, rsp_y, rsp_err}, {2'(e_id), e_y, e_err}); end
            end
            if (phase == 1) begin
                e_id = p_id; e_op = p_op; e_err = (p_op == 7); e_y = gate_ref(p_op, p_a, p_b);
                phase = 2;
            end else if (w >= 0) begin
                p_id = w; p_a = req_a[w]; p_b = req_b[w]; p_op = int'(req_op[3*w +: 3]);
                ptr = (w + 1) % N; phase = 1;
            end else if (phase == 2 && rsp_ready) begin
                phase = 0;
            end
            @(posedge clk);
        end
        @(negedge clk); rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        req_valid = 4'b1000; req_a = 4'b1000; req_b = 4'b1000; req_op = 12'(1) << 9; rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = '0; #1;
        n_checks++; if ({busy, gu_a} !== 2'b11) begin n_fail++; $display("FAIL rm_eval got=%b exp=11", {busy, gu_a}); end
        rst_n = 1'b0; #1;
        n_checks++; if ({busy, rsp_valid, gu_a, gu_b, req_ready} !== 8'b0) begin n_fail++; $display("FAIL rm_eval_rst got=%b exp=00000000", {busy, rsp_valid, gu_a, gu_b, req_ready}); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rm_stale i=%0d got=%b exp=00", i, {rsp_valid, busy}); end
        end
        req_valid = 4'b1000;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_y} !== 4'b1_11_1) begin n_fail++; $display("FAIL rm_resp got=%b exp=1111", {rsp_valid, rsp_id, rsp_y}); end
        rst_n = 1'b0; #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_y, rsp_err, busy, gu_a, gu_b} !== 8'b0) begin
            n_fail++; $display("FAIL rm_resp_rst got=%b exp=00000000", {rsp_valid, rsp_id, rsp_y, rsp_err, busy, gu_a, gu_b}); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b1111; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant got=%b exp=0001", req_ready); end
        @(posedge clk); @(negedge clk);
        req_valid = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_exhaustive();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
